// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles little-endian words from a byte stream,
// writes them from address 0 upward, then verifies an XOR checksum before releasing the core.
module imem_loader #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StCheck,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          idx_q, idx_d;
  logic [7:0]          csum_q, csum_d;
  logic                err_q, err_d;
  logic                hold_q, hold_d;
  logic                ready_q, ready_d;
  logic                wr_en_q, wr_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                xfer;

  // ready_q is high exactly in RECV/CHECK, so this is the handshake as seen by the source.
  assign xfer = byte_valid & ready_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    err_d   = err_q;
    hold_d  = hold_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (word_count == '0 || word_count > DepthW) begin
            err_d   = 1'b1;
            hold_d  = 1'b1;
            state_d = StDone;
          end else begin
            count_d = word_count;
            addr_d  = '0;
            idx_d   = '0;
            csum_d  = '0;
            err_d   = 1'b0;
            hold_d  = 1'b1;
            state_d = StRecv;
          end
        end
      end
      StRecv: begin
        if (xfer) begin
          data_d[{idx_q, 3'b000} +: 8] = byte_in;
          csum_d = csum_q ^ byte_in;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        // The last word leaves the address in place, so a full-depth load never wraps.
        if ({1'b0, addr_q} == count_q - 1'b1) begin
          state_d = StCheck;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StRecv;
        end
      end
      StCheck: begin
        if (xfer) begin
          err_d   = (byte_in != csum_q);
          hold_d  = (byte_in != csum_q);
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered images of the state being entered.
    ready_d = (state_d == StRecv) || (state_d == StCheck);
    wr_en_d = (state_d == StWrite);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign byte_ready = ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign core_hold  = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader; expected writes, checksum result and handshake counts
// come from a word-list model of the load session.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .word_count(word_count),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;

  logic [31:0] words [DEPTH];
  logic [4:0]  seen_addr [$];
  logic [31:0] seen_data [$];
  int xfers, overlaps, dones, busys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Observe the DUT away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) begin
        seen_addr.push_back(wr_addr);
        seen_data.push_back(wr_data);
      end
      if (byte_valid && byte_ready) xfers++;
      if (wr_en && byte_ready) overlaps++;
      if (done) dones++;
      if (busy) busys++;
    end
  end

  task automatic clear_obs();
    seen_addr.delete();
    seen_data.delete();
    xfers = 0;
    overlaps = 0;
    dones = 0;
    busys = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int cyc = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        start      = 1'($urandom_range(0, 1));  // must be ignored while busy
        word_count = 1;
        tick();
      end
    end
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!byte_ready) check("ready_timeout", 0, 1);
    else tick();
  endtask

  task automatic expect_reset_values(input string tag);
    check({tag, "_hold"}, core_hold, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_ready"}, byte_ready, 0);
    check({tag, "_wren"}, wr_en, 0);
    check({tag, "_waddr"}, wr_addr, 0);
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (dones == 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    if (dones == 0) check("done_timeout", 0, 1);
    repeat (3) tick();
  endtask

  // Load words[0..n-1]; the model expects those writes in order and err == corrupt.
  task automatic run_load(input int n, input bit corrupt, input bit gaps, input string tag);
    logic [7:0] csum = 8'h00;
    logic [7:0] bytes [$];
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        bytes.push_back(8'((words[w] >> (8 * k)) & 32'hff));
        csum ^= 8'((words[w] >> (8 * k)) & 32'hff);
      end
    end
    bytes.push_back(corrupt ? (csum ^ 8'h01) : csum);
    clear_obs();
    // The first byte is presented in the start cycle and must not be taken there.
    start      = 1'b1;
    word_count = (ADDR_W + 1)'(n);
    byte_valid = 1'b1;
    byte_in    = bytes[0];
    tick();
    start = 1'b0;
    foreach (bytes[i]) send_byte(bytes[i], gaps);
    byte_valid = 1'b0;
    wait_done();
    check({tag, "_nwr"}, seen_addr.size(), n);
    for (int i = 0; i < n && i < seen_addr.size(); i++) begin
      check({tag, "_waddr"}, seen_addr[i], i);
      check({tag, "_wdata"}, seen_data[i], words[i]);
    end
    check({tag, "_xfers"}, xfers, 4 * n + 1);
    check({tag, "_overlap"}, overlaps, 0);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_err"}, err, corrupt);
    check({tag, "_hold"}, core_hold, corrupt);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_illegal(input int wc, input string tag);
    clear_obs();
    start      = 1'b1;
    word_count = (ADDR_W + 1)'(wc);
    tick();
    start = 1'b0;
    repeat (4) tick();
    check({tag, "_nwr"}, seen_addr.size(), 0);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_busycyc"}, busys, 1);
    check({tag, "_err"}, err, 1);
    check({tag, "_hold"}, core_hold, 1);
  endtask

  initial begin
    #3 rst = 1'b0;
    #1 expect_reset_values("rst");
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    run_load(2, 1'b0, 1'b0, "good");
    run_load(2, 1'b1, 1'b0, "badsum");
    run_load(2, 1'b0, 1'b1, "gapped");

    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      run_load(n, 1'($urandom_range(0, 1)), 1'(t % 2), "rand");
    end

    run_illegal(0, "cnt0");
    run_illegal(33, "cnt33");

    // Abort part-way through word 0 of a full-depth session.
    clear_obs();
    start      = 1'b1;
    word_count = (ADDR_W + 1)'(DEPTH);
    tick();
    start = 1'b0;
    send_byte(8'hAA, 1'b0);
    send_byte(8'h55, 1'b0);
    byte_valid = 1'b0;
    #3 rst = 1'b0;
    #1 expect_reset_values("abort");
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    check("abort_nwr", seen_addr.size(), 0);

    for (int i = 0; i < DEPTH; i++) words[i] = i * 4;
    run_load(DEPTH, 1'b0, 1'b1, "full");
    if (seen_addr.size() == DEPTH) check("full_last_addr", seen_addr[DEPTH-1], DEPTH - 1);
    check("full_addr_hold", wr_addr, DEPTH - 1);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the datapath only reads.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to consecutive instruction-memory addresses from 0, then checks an XOR checksum byte.
- Holds the core in reset until a load completes with a good checksum.

Parameters:
- DEPTH, 32, number of instruction-memory words.
- ADDR_W, 5, word-address width; DEPTH must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begins a load session; sampled only in IDLE.
- word_count  in  ADDR_W+1  number of words to load; sampled with start; legal range 1..DEPTH.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address for the write.
- wr_data  out  32  word to write.
- core_hold  out  1  active-high hold-in-reset for PC/datapath.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at end of a session.
- err  out  1  sticky status of the last session; 1 = checksum mismatch or illegal word_count.

Behaviour:
- All outputs registered; none combinational from inputs.
- A byte transfers when byte_valid & byte_ready at a rising edge.
- Reset (rst=0), asynchronous:
  - state=IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - busy=0, done=0, err=0, core_hold=1.
  - Internal byte index, word counter and checksum cleared.
- States:
  - IDLE, on start=1:
    - If word_count is 0 or >DEPTH: next state DONE with err=1; no writes.
    - Otherwise: latch word_count; clear wr_addr, byte index and checksum; err=0, core_hold=1; next state RECV.
  - RECV:
    - byte_ready=1.
    - Each transfer places the byte at wr_data[8*idx+7:8*idx] (idx 0..3, first byte is LSB) and XORs it into the checksum.
    - After the 4th byte: next state WRITE.
  - WRITE (exactly one cycle):
    - wr_en=1; wr_addr=current address; wr_data=assembled word; byte_ready=0.
    - Next cycle: if this was word word_count-1, go to CHECK; else increment wr_addr and go to RECV.
  - CHECK:
    - byte_ready=1.
    - On transfer: err = (byte_in != checksum); next state DONE.
  - DONE (one cycle):
    - done=1; core_hold=err; next state IDLE.
- Throughput: at most one word per 5 cycles (4 byte cycles + 1 WRITE cycle).
- Latency: start edge to byte_ready=1 is one cycle.
- Boundary conditions:
  - start while busy is ignored.
  - byte_valid in IDLE, WRITE or DONE is not consumed (byte_ready=0); the source holds the byte.
  - start and byte_valid in the same IDLE cycle: the byte is not consumed in that cycle.
  - word_count=DEPTH: the last write is to address DEPTH-1; wr_addr is not incremented past it and never wraps.
  - Between WRITE cycles, wr_addr holds the current address and wr_data holds the partial assembly; consumers qualify both with wr_en.
  - Gaps in byte_valid stall the state without losing byte index or checksum.
  - Reset mid-session aborts to reset values; words already written stay in memory.
  - Illegal word_count produces done with err=1 and no wr_en; core_hold stays 1.
  - err and core_hold hold their values until the next legal start or reset.

Test Plan:
- Reset: assert rst=0 mid-cycle -> immediately core_hold=1, busy=0, done=0, err=0, byte_ready=0, wr_en=0, wr_addr=0.
- Good load: start, word_count=2; bytes 13 00 00 00 93 00 10 00, checksum 90 -> wr_en at addr0 data 0x00000013, then at addr1 data 0x00100093; done pulse; err=0; core_hold=0.
- Bad checksum: same stream with checksum 91 -> identical writes; done pulse; err=1; core_hold stays 1.
- Backpressure: byte_valid held high continuously and randomly gapped -> exactly 4 transfers per word; no transfer during WRITE; same memory contents as the good load.
- Illegal count: word_count=0, then 33 -> no wr_en; done pulse; err=1; busy high for exactly one cycle each.
- Abort and full depth: rst pulse after 2 bytes of word 0, then load 32 words of value i*4 with correct checksum -> writes to addr 0..31 with no wrap; err=0; core_hold=0.
